// File: rtl/clock_divider.sv
// Integer clock divider: registered 50% duty square wave at f_clock / (2*COUNTER_MAX).
// First rising edge COUNTER_MAX clocks after reset release; no flow control, free-running.
module clock_divider #(
    parameter int COUNTER_MAX  = 25,
    parameter int COUNTER_SIZE = 6
) (
    input  logic clock,
    input  logic reset_n,
    output logic divided_clock
);

    // Terminal count held at counter width so the compare never sees stray upper bits.
    localparam logic [COUNTER_SIZE-1:0] TERMINAL = COUNTER_SIZE'(COUNTER_MAX - 1);

    if (COUNTER_MAX < 1) begin : g_max_too_small
        $fatal(1, "clock_divider: COUNTER_MAX must be at least 1");
    end

    if ((longint'(COUNTER_MAX) - 1) >= (longint'(1) << COUNTER_SIZE)) begin : g_counter_too_narrow
        $fatal(1, "clock_divider: COUNTER_SIZE too narrow to hold COUNTER_MAX-1");
    end

    logic [COUNTER_SIZE-1:0] counter;
    logic                    at_terminal;

    assign at_terminal = (counter == TERMINAL);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            counter       <= '0;
            divided_clock <= 1'b0;
        end else if (at_terminal) begin
            counter       <= '0;
            divided_clock <= ~divided_clock;
        end else begin
            counter       <= counter + COUNTER_SIZE'(1);
        end
    end

endmodule

// File: tb/tb_clock_divider.sv
// Directed bench for clock_divider: three instances (25/6, 1/1, 64/6) against a scoreboard of edge-count predictions.
`timescale 1ns/1ps
module tb_clock_divider;

    logic clock;
    logic reset_n;
    logic d25, d1, d64;

    clock_divider #(.COUNTER_MAX(25), .COUNTER_SIZE(6)) dut25 (.clock(clock), .reset_n(reset_n), .divided_clock(d25));
    clock_divider #(.COUNTER_MAX(1),  .COUNTER_SIZE(1)) dut1  (.clock(clock), .reset_n(reset_n), .divided_clock(d1));
    clock_divider #(.COUNTER_MAX(64), .COUNTER_SIZE(6)) dut64 (.clock(clock), .reset_n(reset_n), .divided_clock(d64));

    typedef struct {
        logic e25;
        logic e1;
        logic e64;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    // Edges counted since the last reset release, as seen by the reference model.
    int  k = 0;
    logic p25 = 1'b0, p1 = 1'b0, p64 = 1'b0;
    logic prev63 = 1'b0;
    int  seen63 = 0;
    int  first_rise_k = -1;
    longint rise25[$], fall25[$], rise1[$], rise64[$];

    initial begin
        clock = 1'b0;
        forever #10 clock = ~clock;
    end

    function automatic logic model(input int edges, input int m);
        return ((edges / m) % 2) == 1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // One input clock edge: predict, wait for the edge, sample 1 ns later and score.
    task automatic step();
        exp_t e;
        exp_t got;
        longint t_edge;
        if (reset_n) k++;
        e.e25 = model(k, 25);
        e.e1  = model(k, 1);
        e.e64 = model(k, 64);
        sb.push_back(e);
        @(posedge clock);
        t_edge = longint'($time);
        #1;
        got = sb.pop_front();
        chk("d25", 64'(d25), 64'(got.e25));
        chk("d1",  64'(d1),  64'(got.e1));
        chk("d64", 64'(d64), 64'(got.e64));
        chk("c1_zero", 64'(dut1.counter), 64'd0);
        if (!reset_n) begin
            chk("c25_hold", 64'(dut25.counter), 64'd0);
            chk("c64_hold", 64'(dut64.counter), 64'd0);
        end
        if (prev63 && reset_n) chk("c64_wrap", 64'(dut64.counter), 64'd0);
        prev63 = (dut64.counter == 6'd63);
        if (prev63) seen63++;
        if (!p25 && d25) begin
            rise25.push_back(t_edge);
            if (first_rise_k < 0) first_rise_k = k;
        end
        if (p25 && !d25) fall25.push_back(t_edge);
        if (!p1 && d1) rise1.push_back(t_edge);
        if (!p64 && d64) rise64.push_back(t_edge);
        p25 = d25; p1 = d1; p64 = d64;
    endtask

    initial begin
        reset_n = 1'b0;
        #1;
        chk("rst_d25", 64'(d25), 64'd0);
        chk("rst_d1",  64'(d1),  64'd0);
        chk("rst_d64", 64'(d64), 64'd0);
        chk("rst_c25", 64'(dut25.counter), 64'd0);
        #4 reset_n = 1'b1;

        // Free run from reset with all three ratios.
        for (int i = 0; i < 700; i++) step();

        chk("first_rise_k", 64'(first_rise_k), 64'd25);
        if (rise25.size() >= 5) chk("rise1_time", 64'(rise25[0]), 64'd490);
        else chk("rise25_count", 64'(rise25.size()), 64'd5);
        if (fall25.size() >= 1) chk("fall1_time", 64'(fall25[0]), 64'd990);
        else chk("fall25_count", 64'(fall25.size()), 64'd1);
        if (rise25.size() >= 5) chk("rise5_time", 64'(rise25[4]), 64'd4490);

        if (rise25.size() >= 11 && fall25.size() >= 10) begin
            for (int i = 0; i < 10; i++) begin
                chk("high_ns",   64'(fall25[i] - rise25[i]),     64'd500);
                chk("low_ns",    64'(rise25[i+1] - fall25[i]),   64'd500);
                chk("period_ns", 64'(rise25[i+1] - rise25[i]),   64'd1000);
            end
        end else begin
            chk("periods_seen", 64'(rise25.size()), 64'd14);
        end

        chk("d1_first_rise", 64'(rise1.size() > 0 ? rise1[0] : 0), 64'd10);
        for (int i = 1; i < 6 && i < rise1.size(); i++)
            chk("d1_period", 64'(rise1[i] - rise1[i-1]), 64'd40);

        chk("d64_rises", 64'(rise64.size()), 64'd5);
        for (int i = 1; i < rise64.size(); i++)
            chk("d64_period", 64'(rise64[i] - rise64[i-1]), 64'd2560);
        chk("c64_hit63", 64'(seen63), 64'd10);

        // Hold reset for 100 cycles.
        @(negedge clock);
        reset_n = 1'b0;
        k = 0;
        for (int i = 0; i < 100; i++) step();

        // Release, run until d25 is high, then pull reset between edges.
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 30; i++) step();
        chk("pre_async_high", 64'(d25), 64'd1);
        #4 reset_n = 1'b0;
        #2;
        chk("async_d25", 64'(d25), 64'd0);
        chk("async_c25", 64'(dut25.counter), 64'd0);
        chk("async_d64", 64'(d64), 64'd0);
        k = 0;
        p25 = 1'b0; p1 = 1'b0; p64 = 1'b0;
        prev63 = 1'b0;
        first_rise_k = -1;
        #3 reset_n = 1'b1;
        for (int i = 0; i < 60; i++) step();
        chk("restart_rise_k", 64'(first_rise_k), 64'd25);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety net against a stalled run.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/clock_divider.md
Name: clock_divider

Overview:
- Parameterised integer clock divider. Produces a 50% duty-cycle square wave at f_clock / (2*COUNTER_MAX).
- Used to derive slow timing strobes or clocks (e.g. sensor sampling) from the board system clock.
- Output is a flip-flop output, so it is glitch-free.

Parameters:
- COUNTER_MAX, default 25: half-period of divided_clock in input clock cycles. Legal range 1 .. 2**COUNTER_SIZE.
- COUNTER_SIZE, default 6: width in bits of the internal counter. It must hold the value COUNTER_MAX-1.

Ports:
- clock, input, 1: system clock. All state changes occur on its rising edge.
- reset_n, input, 1: one clock; reset is asynchronous and active-low.
- divided_clock, output, 1: divided square wave, registered.

Behaviour:
- State:
  - counter, COUNTER_SIZE bits.
  - divided_clock register, 1 bit.
- Reset:
  - While reset_n = 0: counter = 0 and divided_clock = 0, immediately, with no clock required.
  - Release is synchronous in effect: the first counting edge is the first rising edge of clock with reset_n = 1.
- Each rising edge of clock with reset_n = 1:
  - If counter == COUNTER_MAX-1: counter <= 0 and divided_clock <= ~divided_clock.
  - Otherwise: counter <= counter + 1, and divided_clock holds.
- Timing consequences:
  - First toggle (0 -> 1) happens on the COUNTER_MAX-th rising edge after reset release.
  - Subsequent toggles occur every COUNTER_MAX edges.
  - Full period is 2*COUNTER_MAX input cycles.
  - The n-th rising edge of divided_clock falls on input edge COUNTER_MAX*(2n-1).
- COUNTER_MAX = 1: divided_clock toggles on every edge (divide by 2). Counter stays 0.
- Counter never exceeds COUNTER_MAX-1. No wrap-around of the COUNTER_SIZE-bit register is possible in legal configurations.
- Elaboration-time checks:
  - COUNTER_MAX < 1 is a fatal error.
  - COUNTER_MAX-1 >= 2**COUNTER_SIZE is a fatal error.
- Comparison is done at COUNTER_SIZE width. The constant COUNTER_MAX-1 is truncated/extended to COUNTER_SIZE bits explicitly.
- Reset asserted mid-period: output forced low and counter cleared at once. After release, the sequence restarts from scratch (first toggle after COUNTER_MAX edges).
- No combinational path from any input to divided_clock.
- divided_clock is intended as a logic/strobe-level clock. Downstream clock-domain handling is the consumer's responsibility.

Decomposition:
- Single module, no sub-modules.
- No shared package needed. COUNTER_MAX/COUNTER_SIZE remain local parameters of the instance.
- A derived localparam for the terminal count (COUNTER_MAX-1 at COUNTER_SIZE bits) lives inside the module.

Test Plan:
1. Defaults (25, 6), 20 ns clock (first rising edge at 10 ns), reset_n low for the first 5 ns then high:
   - divided_clock = 0 until edge 25 (490 ns), then 1.
   - Falls at edge 50 (990 ns).
   - Fifth rising edge at input edge 225 (4490 ns).
2. Reset hold: reset_n = 0 for 100 clock cycles -> divided_clock stays 0 and counter stays 0 throughout.
3. Asynchronous reset: assert reset_n = 0 mid-cycle while divided_clock = 1, between clock edges:
   - divided_clock drops to 0 before the next edge.
   - After release, the next rising edge of divided_clock occurs exactly 25 edges later.
4. Period/duty check over 10 output periods with defaults:
   - High time = low time = 25 input cycles (500 ns).
   - Period = 1000 ns, no jitter.
5. COUNTER_MAX = 1, COUNTER_SIZE = 1: divided_clock toggles on every input edge (period 40 ns). First rise at input edge 1.
6. COUNTER_MAX = 64, COUNTER_SIZE = 6 (terminal count 63, max width):
   - Counter reaches 63 and returns to 0 without overflow.
   - Output period = 128 input cycles.
